// File: rtl/axi_lite_reg_slice_pkg.sv
// Shared types and payload-width helpers for the AXI-lite register slice.
// Widths derive from the address/data widths chosen by each instantiating module.
package axi_pkg;

    typedef enum int {
        SLICE_BYPASS = 0,
        SLICE_FULL   = 1,
        SLICE_HALF   = 2
    } slice_mode_e;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    // Payload layouts: AW/AR {prot, addr}, W {strb, data}, B {resp}, R {resp, data}
    function automatic int ax_pl_w(input int addr_w);
        return addr_w + PROT_W;
    endfunction

    function automatic int w_pl_w(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int b_pl_w();
        return RESP_W;
    endfunction

    function automatic int r_pl_w(input int data_w);
        return data_w + RESP_W;
    endfunction

endpackage

// File: rtl/axi_lite_reg_slice_if.sv
// AXI-lite five-channel bundle; master modport drives AW/W/AR and B/R ready.
// clk/rstn are carried so both sides of a link share one clock/reset pair.
interface axi_lite_channel
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    logic                    aw_vld, aw_rdy;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [PROT_W-1:0]       aw_prot;
    logic                    w_vld, w_rdy;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_vld, b_rdy;
    logic [RESP_W-1:0]       b_resp;
    logic                    ar_vld, ar_rdy;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [PROT_W-1:0]       ar_prot;
    logic                    r_vld, r_rdy;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [RESP_W-1:0]       r_resp;

    logic unused_clk_rstn;
    assign unused_clk_rstn = clk & rstn;

    modport master (
        output aw_vld, aw_addr, aw_prot, input  aw_rdy,
        output w_vld, w_data, w_strb,    input  w_rdy,
        input  b_vld, b_resp,            output b_rdy,
        output ar_vld, ar_addr, ar_prot, input  ar_rdy,
        input  r_vld, r_data, r_resp,    output r_rdy
    );

    modport slave (
        input  aw_vld, aw_addr, aw_prot, output aw_rdy,
        input  w_vld, w_data, w_strb,    output w_rdy,
        output b_vld, b_resp,            input  b_rdy,
        input  ar_vld, ar_addr, ar_prot, output ar_rdy,
        output r_vld, r_data, r_resp,    input  r_rdy
    );
endinterface

// File: rtl/axi_lite_reg_slice_skid.sv
// One valid/ready pipeline stage: bypass wires, 2-entry skid (full) or 1-entry (half).
// Latency 0 / 1 / 1 cycles; in_ready comes from a flop in full and half modes.
module axi_skid_buf
    import axi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = SLICE_FULL
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    generate
        if (MODE == SLICE_BYPASS) begin : g_bypass
            logic w_unused_clk;
            assign w_unused_clk = clk & rstn;
            assign out_valid    = in_valid;
            assign in_ready     = out_ready;
            assign out_data     = in_data;
        end else if (MODE == SLICE_HALF) begin : g_half
            logic             r_vld;
            logic [WIDTH-1:0] r_dat;

            assign in_ready  = !r_vld;
            assign out_valid = r_vld;
            assign out_data  = r_dat;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_vld <= 1'b0;
                    r_dat <= '0;
                end else if (r_vld) begin
                    if (out_ready) r_vld <= 1'b0;
                end else if (in_valid) begin
                    r_vld <= 1'b1;
                    r_dat <= in_data;
                end
            end
        end else begin : g_full
            logic             r_main_vld, r_skid_vld;
            logic [WIDTH-1:0] r_main_dat, r_skid_dat;
            logic             w_acc, w_drain;

            assign in_ready  = !r_skid_vld;
            assign out_valid = r_main_vld;
            assign out_data  = r_main_dat;
            assign w_acc     = in_valid && !r_skid_vld;
            assign w_drain   = r_main_vld && out_ready;

            // Skid only ever fills while main is stalled, so a full skid implies a full main.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                    r_main_dat <= '0;
                    r_skid_dat <= '0;
                end else if (w_drain || !r_main_vld) begin
                    if (r_skid_vld) begin
                        r_main_dat <= r_skid_dat;
                        r_main_vld <= 1'b1;
                        r_skid_vld <= 1'b0;
                    end else begin
                        r_main_vld <= w_acc;
                        if (w_acc) r_main_dat <= in_data;
                    end
                end else if (w_acc) begin
                    r_skid_vld <= 1'b1;
                    r_skid_dat <= in_data;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/axi_lite_reg_slice.sv
// AXI-lite register slice: independent skid stage per channel between bridge and BRAM ctrl.
// Latency 0 (bypass) or 1 cycle per channel; backpressure handled per channel, no coupling.
module axi_lite_reg_slice
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int AW_MODE    = SLICE_FULL,
    parameter int W_MODE     = SLICE_FULL,
    parameter int B_MODE     = SLICE_FULL,
    parameter int AR_MODE    = SLICE_FULL,
    parameter int R_MODE     = SLICE_FULL
) (
    input logic             clk,
    input logic             rstn,
    axi_lite_channel.slave  master,
    axi_lite_channel.master slave
);
    localparam int AX_W = ax_pl_w(ADDR_WIDTH);
    localparam int WD_W = w_pl_w(DATA_WIDTH);
    localparam int B_W  = b_pl_w();
    localparam int R_W  = r_pl_w(DATA_WIDTH);

    logic [AX_W-1:0] w_aw_in, w_aw_out, w_ar_in, w_ar_out;
    logic [WD_W-1:0] w_w_in, w_w_out;
    logic [B_W-1:0]  w_b_in, w_b_out;
    logic [R_W-1:0]  w_r_in, w_r_out;

    assign w_aw_in                        = {master.aw_prot, master.aw_addr};
    assign {slave.aw_prot, slave.aw_addr} = w_aw_out;
    assign w_w_in                         = {master.w_strb, master.w_data};
    assign {slave.w_strb, slave.w_data}   = w_w_out;
    assign w_ar_in                        = {master.ar_prot, master.ar_addr};
    assign {slave.ar_prot, slave.ar_addr} = w_ar_out;
    // Reverse channels flow from the BRAM controller back to the bridge.
    assign w_b_in                         = slave.b_resp;
    assign master.b_resp                  = w_b_out;
    assign w_r_in                         = {slave.r_resp, slave.r_data};
    assign {master.r_resp, master.r_data} = w_r_out;

    axi_skid_buf #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
        .clk(clk), .rstn(rstn),
        .in_valid(master.aw_vld), .in_ready(master.aw_rdy), .in_data(w_aw_in),
        .out_valid(slave.aw_vld), .out_ready(slave.aw_rdy), .out_data(w_aw_out)
    );

    axi_skid_buf #(.WIDTH(WD_W), .MODE(W_MODE)) u_w (
        .clk(clk), .rstn(rstn),
        .in_valid(master.w_vld), .in_ready(master.w_rdy), .in_data(w_w_in),
        .out_valid(slave.w_vld), .out_ready(slave.w_rdy), .out_data(w_w_out)
    );

    axi_skid_buf #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk(clk), .rstn(rstn),
        .in_valid(slave.b_vld), .in_ready(slave.b_rdy), .in_data(w_b_in),
        .out_valid(master.b_vld), .out_ready(master.b_rdy), .out_data(w_b_out)
    );

    axi_skid_buf #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
        .clk(clk), .rstn(rstn),
        .in_valid(master.ar_vld), .in_ready(master.ar_rdy), .in_data(w_ar_in),
        .out_valid(slave.ar_vld), .out_ready(slave.ar_rdy), .out_data(w_ar_out)
    );

    axi_skid_buf #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk(clk), .rstn(rstn),
        .in_valid(slave.r_vld), .in_ready(slave.r_rdy), .in_data(w_r_in),
        .out_valid(master.r_vld), .out_ready(master.r_rdy), .out_data(w_r_out)
    );
endmodule
